sa_col_ctrl: RTL

//  Sequencer for a 1-D weight-stationary column of NUM_PE PE cells.
//  - PE k's psum_out feeds PE k+1's psum_in; PE0 psum_in is tied to 0 outside this block.
//  - Loads one 8-bit weight per PE over a handshake, then streams activation vectors

---
 rtl/sa_col_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sa_col_ctrl.sv
// Sequencer for a weight-stationary column of NUM_PE PE cells: weight load,
// skewed activation streaming and result-valid tracking for the last PE.
module sa_col_ctrl #(
  parameter int NUM_PE = 4,
  parameter int LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  reload_w,
  input  logic [LEN_W-1:0]      num_vec,
  input  logic                  w_valid,
  input  logic [7:0]            w_data,
  output logic                  w_ready,
  input  logic                  a_valid,
  input  logic [NUM_PE*8-1:0]   a_data,
  output logic                  a_ready,
  output logic [NUM_PE-1:0]     pe_en_store,
  output logic [NUM_PE*8-1:0]   pe_in,
  output logic                  res_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = $clog2(NUM_PE);
  // Lane k (k>=1) owns k skew stages; lanes are packed back to back.
  localparam int NSKEW = NUM_PE * (NUM_PE - 1) / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      vec_cnt_q, vec_cnt_d;
  logic [IDX_W-1:0]      w_idx_q, w_idx_d;
  logic [NUM_PE:0]       vld_q, vld_d;
  logic [8*NSKEW-1:0]    skew_q, skew_d;
  logic [NUM_PE-1:0]     pe_en_store_q, pe_en_store_d;
  logic [NUM_PE*8-1:0]   pe_in_q, pe_in_d;
  logic                  w_hs, a_hs;

  // A transfer happens on the rising edge where valid & ready are both high;
  // ready depends only on state, never on valid.
  assign w_ready = (state_q == S_LOAD);
  assign a_ready = (state_q == S_COMPUTE);
  assign w_hs    = w_valid & w_ready;
  assign a_hs    = a_valid & a_ready;

  assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done        = (state_q == S_FIN);
  assign res_valid   = vld_q[NUM_PE];
  assign pe_en_store = pe_en_store_q;
  assign pe_in       = pe_in_q;

  always_comb begin
    state_d   = state_q;
    vec_cnt_d = vec_cnt_q;
    w_idx_d   = w_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_cnt_d = num_vec;
          w_idx_d   = '0;
          if (reload_w)             state_d = S_LOAD;
          else if (num_vec != '0)   state_d = S_COMPUTE;
          else                      state_d = S_FIN;
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          w_idx_d = w_idx_q + IDX_W'(1);
          if (w_idx_q == IDX_W'(NUM_PE - 1)) begin
            w_idx_d = '0;
            state_d = (vec_cnt_q != '0) ? S_COMPUTE : S_FIN;
          end
        end
      end
      S_COMPUTE: begin
        if (a_hs) begin
          vec_cnt_d = vec_cnt_q - LEN_W'(1);
          if (vec_cnt_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vld_q == '0) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_d         = {vld_q[NUM_PE-1:0], a_hs};
    skew_d        = '0;
    pe_en_store_d = '0;
    pe_in_d       = '0;
    for (int k = 1; k < NUM_PE; k++) begin
      skew_d[8*(k*(k-1)/2) +: 8] = a_hs ? a_data[8*k +: 8] : 8'd0;
      for (int s = 1; s < k; s++) begin
        skew_d[8*(k*(k-1)/2 + s) +: 8] = skew_q[8*(k*(k-1)/2 + s - 1) +: 8];
      end
    end
    if (w_ready) begin
      if (w_hs) begin
        pe_en_store_d[w_idx_q]    = 1'b1;
        pe_in_d[8*w_idx_q +: 8]   = w_data;
      end
    end else begin
      // The last skew stage of lane k feeds the registered pe_in[k].
      pe_in_d[7:0] = a_hs ? a_data[7:0] : 8'd0;
      for (int k = 1; k < NUM_PE; k++) begin
        pe_in_d[8*k +: 8] = skew_q[8*(k*(k-1)/2 + k - 1) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vec_cnt_q     <= '0;
      w_idx_q       <= '0;
      vld_q         <= '0;
      skew_q        <= '0;
      pe_en_store_q <= '0;
      pe_in_q       <= '0;
    end else begin
      state_q       <= state_d;
      vec_cnt_q     <= vec_cnt_d;
      w_idx_q       <= w_idx_d;
      vld_q         <= vld_d;
      skew_q        <= skew_d;
      pe_en_store_q <= pe_en_store_d;
      pe_in_q       <= pe_in_d;
    end
  end

endmodule
